// File: rtl/seg_display_ctrl.sv
// Eight-digit multiplexed common-anode seven-segment controller.
// Holds a 32-bit word written by seg_we and scans it out as hex nibbles, digit 0 rightmost.
module seg_display_ctrl #(
   parameter int SCAN_DIV = 100000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        seg_we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [7:0]  an,
   output logic [7:0]  seg
);

   localparam int CW = $clog2(SCAN_DIV);

   logic [31:0]     disp_reg;
   logic [CW-1:0]   scan_cnt;
   logic [2:0]      digit_idx;
   logic            scan_tick;
   logic [7:0][3:0] nib;
   logic [7:0]      blank;

   // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   assign nib       = disp_reg;
   assign rdata     = disp_reg;
   assign scan_tick = (scan_cnt == CW'(SCAN_DIV - 1));

   // A digit is a leading zero when it and every digit above it are zero.
   for (genvar g = 0; g < 8; g++) begin : g_blank
      if (g == 0) begin : g_d0
         assign blank[g] = 1'b0;
      end else begin : g_dn
         assign blank[g] = BLANK_LZ && (disp_reg[31:4*g] == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_reg <= '0;
      end else if (seg_we) begin
         disp_reg <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt  <= '0;
         digit_idx <= '0;
      end else if (scan_tick) begin
         scan_cnt  <= '0;
         digit_idx <= digit_idx + 3'd1;
      end else begin
         scan_cnt  <= scan_cnt + CW'(1);
      end
   end

   // Registered drive; dp held dark, blanked digits keep their anode pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= 8'hFF;
         seg <= 8'hFF;
      end else begin
         an  <= ~(8'b1 << digit_idx);
         seg <= blank[digit_idx] ? 8'hFF : {1'b1, hex7(nib[digit_idx])};
      end
   end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: one unblanked and one blanking instance, SCAN_DIV=4.
module tb_seg_display_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        seg_we = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata0, rdata1;
   logic [7:0]  an0, an1, seg0, seg1;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   seg_display_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .seg_we(seg_we), .wdata(wdata),
      .rdata(rdata0), .an(an0), .seg(seg0));

   seg_display_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .seg_we(seg_we), .wdata(wdata),
      .rdata(rdata1), .an(an1), .seg(seg1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      seg_we = 1'b0;
      rst_n  = 1'b0;
      #1;
      rst_n  = 1'b1;
   endtask

   // Hand-decoded patterns for 32'h89ABCDEF, digit 0 first.
   function automatic logic [7:0] full_seg(input int d);
      case (d)
         0: full_seg = 8'h8E;
         1: full_seg = 8'h86;
         2: full_seg = 8'hA1;
         3: full_seg = 8'hC6;
         4: full_seg = 8'h83;
         5: full_seg = 8'h88;
         6: full_seg = 8'h90;
         default: full_seg = 8'h80;
      endcase
   endfunction

   // Hand-decoded patterns for 32'h12345678.
   function automatic logic [7:0] hold_seg(input int d);
      case (d)
         0: hold_seg = 8'h80;
         1: hold_seg = 8'hF8;
         2: hold_seg = 8'h82;
         3: hold_seg = 8'h92;
         4: hold_seg = 8'h99;
         5: hold_seg = 8'hB0;
         6: hold_seg = 8'hA4;
         default: hold_seg = 8'hF9;
      endcase
   endfunction

   // 32'h00000305 with leading zeros blanked.
   function automatic logic [7:0] lz_seg(input int d);
      case (d)
         0: lz_seg = 8'h92;
         1: lz_seg = 8'hC0;
         2: lz_seg = 8'hB0;
         default: lz_seg = 8'hFF;
      endcase
   endfunction

   task automatic test_reset();
      do_reset();
      seg_we = 1'b1; wdata = 32'h89ABCDEF;
      tick();
      seg_we = 1'b0;
      repeat (6) tick();
      seg_we = 1'b1; wdata = 32'hFFFF_FFFF;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks += 3;
      if (an0 !== 8'hFF) begin n_fail++; $display("FAIL reset_an: got %h want ff", an0); end
      if (seg0 !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h want ff", seg0); end
      if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata0); end
      n_checks += 3;
      if (an1 !== 8'hFF) begin n_fail++; $display("FAIL reset_an_lz: got %h want ff", an1); end
      if (seg1 !== 8'hFF) begin n_fail++; $display("FAIL reset_seg_lz: got %h want ff", seg1); end
      if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_lz: got %h want 0", rdata1); end
      tick();
      n_checks += 2;
      if (an0 !== 8'hFF) begin n_fail++; $display("FAIL reset_hold_an: got %h want ff", an0); end
      if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL reset_hold_rdata: got %h want 0", rdata0); end
      seg_we = 1'b0;
      rst_n  = 1'b1;
      tick();
      n_checks += 4;
      if (an0 !== 8'hFE) begin n_fail++; $display("FAIL post_reset_an: got %h want fe", an0); end
      if (seg0 !== 8'hC0) begin n_fail++; $display("FAIL post_reset_seg: got %h want c0", seg0); end
      if (an1 !== 8'hFE) begin n_fail++; $display("FAIL post_reset_an_lz: got %h want fe", an1); end
      if (seg1 !== 8'hC0) begin n_fail++; $display("FAIL post_reset_seg_lz: got %h want c0", seg1); end
   endtask

   task automatic test_full_scan();
      logic [7:0] exp_an;
      int d;
      do_reset();
      seg_we = 1'b1; wdata = 32'h89ABCDEF;
      tick();
      seg_we = 1'b0;
      n_checks += 3;
      if (rdata0 !== 32'h89ABCDEF) begin n_fail++; $display("FAIL scan_rdata: got %h want 89abcdef", rdata0); end
      if (an0 !== 8'hFE) begin n_fail++; $display("FAIL scan_first_an: got %h want fe", an0); end
      if (seg0 !== 8'hC0) begin n_fail++; $display("FAIL scan_first_seg: got %h want c0", seg0); end
      for (int c = 2; c <= 34; c++) begin
         tick();
         d = ((c - 1) / 4) % 8;
         exp_an = 8'hFF;
         exp_an[d] = 1'b0;
         n_checks += 2;
         if (an0 !== exp_an) begin n_fail++; $display("FAIL scan_an c=%0d: got %h want %h", c, an0, exp_an); end
         if (seg0 !== full_seg(d)) begin n_fail++; $display("FAIL scan_seg c=%0d: got %h want %h", c, seg0, full_seg(d)); end
      end
   endtask

   task automatic test_blanking();
      logic [7:0] exp_an, exp_seg;
      int d;
      do_reset();
      seg_we = 1'b1; wdata = 32'h00000305;
      tick();
      seg_we = 1'b0;
      for (int c = 2; c <= 33; c++) begin
         tick();
         d = ((c - 1) / 4) % 8;
         exp_an = 8'hFF;
         exp_an[d] = 1'b0;
         n_checks += 2;
         if (an1 !== exp_an) begin n_fail++; $display("FAIL lz_an c=%0d: got %h want %h", c, an1, exp_an); end
         if (seg1 !== lz_seg(d)) begin n_fail++; $display("FAIL lz_seg c=%0d: got %h want %h", c, seg1, lz_seg(d)); end
      end
      seg_we = 1'b1; wdata = 32'h0;
      tick();
      seg_we = 1'b0;
      n_checks += 1;
      if (seg1 !== 8'h92) begin n_fail++; $display("FAIL lz_zero_write_edge: got %h want 92", seg1); end
      for (int c = 35; c <= 66; c++) begin
         tick();
         d = ((c - 1) / 4) % 8;
         exp_an = 8'hFF;
         exp_an[d] = 1'b0;
         exp_seg = (d == 0) ? 8'hC0 : 8'hFF;
         n_checks += 2;
         if (an1 !== exp_an) begin n_fail++; $display("FAIL zero_an c=%0d: got %h want %h", c, an1, exp_an); end
         if (seg1 !== exp_seg) begin n_fail++; $display("FAIL zero_seg c=%0d: got %h want %h", c, seg1, exp_seg); end
      end
   endtask

   task automatic test_write_active();
      do_reset();
      seg_we = 1'b1; wdata = 32'h5;
      tick();
      seg_we = 1'b0;
      tick();
      n_checks += 1;
      if (seg0 !== 8'h92) begin n_fail++; $display("FAIL active_pre: got %h want 92", seg0); end
      seg_we = 1'b1; wdata = 32'h7;
      tick();
      seg_we = 1'b0;
      n_checks += 2;
      if (seg0 !== 8'h92) begin n_fail++; $display("FAIL active_edge1: got %h want 92", seg0); end
      if (an0 !== 8'hFE) begin n_fail++; $display("FAIL active_edge1_an: got %h want fe", an0); end
      tick();
      n_checks += 3;
      if (seg0 !== 8'hF8) begin n_fail++; $display("FAIL active_edge2: got %h want f8", seg0); end
      if (an0 !== 8'hFE) begin n_fail++; $display("FAIL active_edge2_an: got %h want fe", an0); end
      if (rdata0 !== 32'h7) begin n_fail++; $display("FAIL active_rdata: got %h want 7", rdata0); end
   endtask

   task automatic test_write_terminal();
      do_reset();
      repeat (3) tick();
      seg_we = 1'b1; wdata = 32'h00000020;
      tick();
      seg_we = 1'b0;
      n_checks += 2;
      if (an0 !== 8'hFE) begin n_fail++; $display("FAIL tc_edge_an: got %h want fe", an0); end
      if (seg0 !== 8'hC0) begin n_fail++; $display("FAIL tc_edge_seg: got %h want c0", seg0); end
      tick();
      n_checks += 4;
      if (an0 !== 8'hFD) begin n_fail++; $display("FAIL tc_next_an: got %h want fd", an0); end
      if (seg0 !== 8'hA4) begin n_fail++; $display("FAIL tc_next_seg: got %h want a4", seg0); end
      if (an1 !== 8'hFD) begin n_fail++; $display("FAIL tc_next_an_lz: got %h want fd", an1); end
      if (seg1 !== 8'hA4) begin n_fail++; $display("FAIL tc_next_seg_lz: got %h want a4", seg1); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      seg_we = 1'b1;
      wdata = 32'h11111111; tick();
      wdata = 32'h22222222; tick();
      wdata = 32'hCAFEF00D; tick();
      seg_we = 1'b0;
      n_checks += 1;
      if (rdata0 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_rdata: got %h want cafef00d", rdata0); end
   endtask

   task automatic test_hold();
      logic [7:0] exp_an;
      int d;
      do_reset();
      seg_we = 1'b1; wdata = 32'h12345678;
      tick();
      seg_we = 1'b0;
      for (int c = 2; c <= 65; c++) begin
         wdata = $urandom;
         tick();
         d = ((c - 1) / 4) % 8;
         exp_an = 8'hFF;
         exp_an[d] = 1'b0;
         n_checks += 3;
         if (rdata0 !== 32'h12345678) begin n_fail++; $display("FAIL hold_rdata c=%0d: got %h want 12345678", c, rdata0); end
         if (an0 !== exp_an) begin n_fail++; $display("FAIL hold_an c=%0d: got %h want %h", c, an0, exp_an); end
         if (seg0 !== hold_seg(d)) begin n_fail++; $display("FAIL hold_seg c=%0d: got %h want %h", c, seg0, hold_seg(d)); end
      end
   endtask

   initial begin
      #7;
      rst_n = 1'b1;
      test_reset();
      test_full_scan();
      test_blanking();
      test_write_active();
      test_write_terminal();
      test_back_to_back();
      test_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
